char_sprite_renderer: RTL and testbench

- Pixel-colour source for the player character; drives the 8-bit RRRGGGBB colour that the VGA driver consumes.
- Takes the driver's next_x/next_y scan coordinates and the player's posx/posy, and returns a registered colour for that pixel.
- Runs a frame-synchronous attack animation FSM (idle → windup → strike → recover) that selects the sprite frame and palette, and draws a weapon rectangle during strike.
- Sits between the player logic (upstream) and the VGA driver (downstream), on the 25 MHz pixel clock.

---
 rtl/char_sprite_renderer_pkg.sv | 22 ++
 rtl/char_sprite_rom.sv | 56 +++++
 rtl/char_sprite_renderer.sv | 199 +++++++++++++++++++
 tb/tb_char_sprite_renderer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/char_sprite_renderer_pkg.sv
// Shared definitions for the player sprite renderer: animation state encoding,
// palette constants and the visible-area size shared with the VGA driver.
package char_sprite_renderer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WINDUP  = 2'd1,
        ST_STRIKE  = 2'd2,
        ST_RECOVER = 2'd3
    } anim_state_t;

    localparam logic [7:0] COL_IDLE    = 8'hFF;
    localparam logic [7:0] COL_WINDUP  = 8'hFC;
    localparam logic [7:0] COL_STRIKE  = 8'hE0;
    localparam logic [7:0] COL_RECOVER = 8'h92;
    localparam logic [7:0] COL_WEAPON  = 8'hDB;
    localparam logic [7:0] COL_BG      = 8'h00;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

endpackage

// File: rtl/char_sprite_rom.sv
// Combinational 1bpp sprite bitmap: two frames (0 = idle/recover, 1 = windup/strike).
// Rows are stored as 16-pixel words; other sprite sizes tile that art.
module char_sprite_rom #(
    parameter int SIZE = 16
) (
    input  logic [$clog2(SIZE):0] addr,
    output logic [SIZE-1:0]       data
);

    logic [4:0]  idx_s;
    logic [15:0] word_s;

    assign idx_s = {addr[$clog2(SIZE)], 4'(addr[$clog2(SIZE)-1:0])};
    assign data  = SIZE'({word_s, word_s});

    // Constant bitmap table, bit 0 is the leftmost pixel when facing right.
    always_comb begin
        word_s = 16'h0000;
        case (idx_s)
            5'd0:  word_s = 16'hFFFF;
            5'd1:  word_s = 16'h0FF0;
            5'd2:  word_s = 16'h0FF0;
            5'd3:  word_s = 16'h07E0;
            5'd4:  word_s = 16'h03C0;
            5'd5:  word_s = 16'h1FF8;
            5'd6:  word_s = 16'h3FFC;
            5'd7:  word_s = 16'h7FFE;
            5'd8:  word_s = 16'hFFFF;
            5'd9:  word_s = 16'h3FFC;
            5'd10: word_s = 16'hFFFF;
            5'd11: word_s = 16'h1FF8;
            5'd12: word_s = 16'h0C30;
            5'd13: word_s = 16'h0C30;
            5'd14: word_s = 16'h003F;
            5'd15: word_s = 16'h3C3C;
            5'd16: word_s = 16'h07E0;
            5'd17: word_s = 16'h0FF0;
            5'd18: word_s = 16'h0FF0;
            5'd19: word_s = 16'h07E0;
            5'd20: word_s = 16'h03C0;
            5'd21: word_s = 16'h3FF8;
            5'd22: word_s = 16'h7FFC;
            5'd23: word_s = 16'hFFFE;
            5'd24: word_s = 16'hFFF0;
            5'd25: word_s = 16'h3FF0;
            5'd26: word_s = 16'h1FF0;
            5'd27: word_s = 16'h1FF8;
            5'd28: word_s = 16'h1818;
            5'd29: word_s = 16'h300C;
            5'd30: word_s = 16'h600E;
            5'd31: word_s = 16'hE00F;
            default: word_s = 16'h0000;
        endcase
    end

endmodule

// File: rtl/char_sprite_renderer.sv
// Player character pixel source: frame-synchronous attack animation FSM plus
// sprite/weapon hit test producing a registered RRRGGGBB colour one cycle later.
module char_sprite_renderer #(
    parameter int SIZE           = 16,
    parameter int WEAPON_LEN     = 12,
    parameter int WEAPON_H       = 4,
    parameter int WINDUP_FRAMES  = 4,
    parameter int STRIKE_FRAMES  = 6,
    parameter int RECOVER_FRAMES = 4,
    parameter int H_ACTIVE       = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic       frame_tick,
    input  logic [9:0] posx,
    input  logic [9:0] posy,
    input  logic       left,
    input  logic       right,
    input  logic       attack,
    output logic [7:0] color,
    output logic       hit,
    output logic [1:0] anim_state,
    output logic       strike_active
);
    import char_sprite_renderer_pkg::*;

    localparam int LOG = $clog2(SIZE);

    anim_state_t   state_r, state_nx_s;
    logic [7:0]    cnt_r, cnt_nx_s, last_cnt_s;
    logic          facing_left_r, facing_nx_s;
    logic          strike_r;
    logic [7:0]    color_r, color_s;
    logic          hit_r, hit_s;

    logic [10:0]   x_s, y_s, px_s, py_s, du_s, dv_s, wy_s, wl_lo_s;
    logic [11:0]   wl_raw_s;
    logic [LOG-1:0] u_s, u_m_s;
    logic          in_view_s, in_box_s, in_wrow_s, in_wpn_s, frame_s, sprite_bit_s;
    logic [SIZE-1:0] rom_data_s;
    logic [7:0]    pal_s;

    // State, counter and facing register; all advance only via the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            facing_left_r <= 1'b0;
            strike_r      <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            facing_left_r <= facing_nx_s;
            strike_r      <= (state_nx_s == ST_STRIKE);
        end
    end

    // Last counter value before leaving the current animation state.
    always_comb begin
        last_cnt_s = 8'd0;
        case (state_r)
            ST_WINDUP:  last_cnt_s = 8'(WINDUP_FRAMES - 1);
            ST_STRIKE:  last_cnt_s = 8'(STRIKE_FRAMES - 1);
            ST_RECOVER: last_cnt_s = 8'(RECOVER_FRAMES - 1);
            default:    last_cnt_s = 8'd0;
        endcase
    end

    // Next-state logic; nothing moves except on frame_tick so a frame never tears.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        facing_nx_s = facing_left_r;
        if (frame_tick) begin
            if (left && !right) begin
                facing_nx_s = 1'b1;
            end else if (right && !left) begin
                facing_nx_s = 1'b0;
            end else begin
                facing_nx_s = facing_left_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (attack) begin
                        state_nx_s = ST_WINDUP;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                    cnt_nx_s = 8'd0;
                end
                ST_WINDUP, ST_STRIKE, ST_RECOVER: begin
                    if (cnt_r == last_cnt_s) begin
                        state_nx_s = anim_state_t'(state_r + 2'd1);
                        cnt_nx_s   = 8'd0;
                    end else begin
                        cnt_nx_s   = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 8'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // 11-bit geometry so posx+SIZE+WEAPON_LEN can never wrap.
    assign x_s  = {1'b0, next_x};
    assign y_s  = {1'b0, next_y};
    assign px_s = {1'b0, posx};
    assign py_s = {1'b0, posy};
    assign du_s = x_s - px_s;
    assign dv_s = y_s - py_s;
    assign u_s  = du_s[LOG-1:0];
    assign u_m_s = facing_left_r ? (LOG'(SIZE - 1) - u_s) : u_s;

    assign in_view_s = (x_s < 11'(H_ACTIVE)) && (y_s < 11'(V_ACTIVE));
    assign in_box_s  = (x_s >= px_s) && (x_s < px_s + 11'(SIZE)) &&
                       (y_s >= py_s) && (y_s < py_s + 11'(SIZE));

    assign frame_s = (state_r == ST_WINDUP) || (state_r == ST_STRIKE);

    char_sprite_rom #(.SIZE(SIZE)) u_rom (
        .addr ({frame_s, dv_s[LOG-1:0]}),
        .data (rom_data_s)
    );

    assign sprite_bit_s = in_view_s && in_box_s && rom_data_s[u_m_s];

    // Left weapon edge goes negative near the screen edge and is clamped to column 0.
    assign wl_raw_s  = {2'b00, posx} - 12'(WEAPON_LEN);
    assign wl_lo_s   = wl_raw_s[11] ? 11'd0 : wl_raw_s[10:0];
    assign wy_s      = py_s + 11'(SIZE / 2) - 11'(WEAPON_H / 2);
    assign in_wrow_s = (y_s >= wy_s) && (y_s < wy_s + 11'(WEAPON_H));

    // Weapon box, only while striking and only on the facing side.
    always_comb begin
        in_wpn_s = 1'b0;
        if (state_r == ST_STRIKE && in_view_s && in_wrow_s) begin
            if (facing_left_r) begin
                in_wpn_s = (x_s >= wl_lo_s) && (x_s < px_s);
            end else begin
                in_wpn_s = (x_s >= px_s + 11'(SIZE)) &&
                           (x_s < px_s + 11'(SIZE) + 11'(WEAPON_LEN));
            end
        end else begin
            in_wpn_s = 1'b0;
        end
    end

    // Palette for the current animation state.
    always_comb begin
        pal_s = COL_IDLE;
        case (state_r)
            ST_IDLE:    pal_s = COL_IDLE;
            ST_WINDUP:  pal_s = COL_WINDUP;
            ST_STRIKE:  pal_s = COL_STRIKE;
            ST_RECOVER: pal_s = COL_RECOVER;
            default:    pal_s = COL_IDLE;
        endcase
    end

    // Colour priority: sprite over weapon over background.
    always_comb begin
        color_s = COL_BG;
        hit_s   = 1'b0;
        if (sprite_bit_s) begin
            color_s = pal_s;
            hit_s   = 1'b1;
        end else if (in_wpn_s) begin
            color_s = COL_WEAPON;
            hit_s   = 1'b1;
        end else begin
            color_s = COL_BG;
            hit_s   = 1'b0;
        end
    end

    // Output pixel register, fixed one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_r <= COL_BG;
            hit_r   <= 1'b0;
        end else begin
            color_r <= color_s;
            hit_r   <= hit_s;
        end
    end

    assign color         = color_r;
    assign hit           = hit_r;
    assign anim_state    = state_r;
    assign strike_active = strike_r;

endmodule

// File: tb/tb_char_sprite_renderer.sv
// Directed bench for char_sprite_renderer: IDLE pixel table plus hand-written
// animation, weapon, facing and reset sequences.
module tb_char_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst, frame_tick, left, right, attack;
    logic [9:0] next_x, next_y, posx, posy;
    logic [7:0] color;
    logic       hit, strike_active;
    logic [1:0] anim_state;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [9:0] px, py, nx, ny;
        logic [7:0] col;
        logic       hit;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    char_sprite_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .next_x        (next_x),
        .next_y        (next_y),
        .frame_tick    (frame_tick),
        .posx          (posx),
        .posy          (posy),
        .left          (left),
        .right         (right),
        .attack        (attack),
        .color         (color),
        .hit           (hit),
        .anim_state    (anim_state),
        .strike_active (strike_active)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pix(input string name, input int px, input int py, input int nx, input int ny,
                       input int col, input int h);
        @(negedge clk);
        posx = 10'(px); posy = 10'(py); next_x = 10'(nx); next_y = 10'(ny);
        @(posedge clk);
        #1;
        check({name, "_color"}, int'(color), col);
        check({name, "_hit"}, int'(hit), h);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    function automatic int exp_state(input int k);
        if (k <= 3) return 1;
        else if (k <= 9) return 2;
        else if (k <= 13) return 3;
        else if (k == 14) return 0;
        else return 1;
    endfunction

    initial begin
        vecs[0]  = '{10'd100, 10'd200, 10'd100, 10'd200, 8'hFF, 1'b1};
        vecs[1]  = '{10'd100, 10'd200, 10'd116, 10'd200, 8'h00, 1'b0};
        vecs[2]  = '{10'd100, 10'd200, 10'd115, 10'd200, 8'hFF, 1'b1};
        vecs[3]  = '{10'd100, 10'd200, 10'd99,  10'd200, 8'h00, 1'b0};
        vecs[4]  = '{10'd100, 10'd200, 10'd100, 10'd216, 8'h00, 1'b0};
        vecs[5]  = '{10'd100, 10'd200, 10'd100, 10'd201, 8'h00, 1'b0};
        vecs[6]  = '{10'd100, 10'd200, 10'd104, 10'd201, 8'hFF, 1'b1};
        vecs[7]  = '{10'd630, 10'd100, 10'd640, 10'd100, 8'h00, 1'b0};
        vecs[8]  = '{10'd630, 10'd100, 10'd639, 10'd100, 8'hFF, 1'b1};
        vecs[9]  = '{10'd100, 10'd470, 10'd102, 10'd480, 8'h00, 1'b0};
        vecs[10] = '{10'd100, 10'd470, 10'd102, 10'd479, 8'hFF, 1'b1};
        vecs[11] = '{10'd100, 10'd200, 10'd120, 10'd208, 8'h00, 1'b0};

        rst = 1'b1; frame_tick = 1'b0; left = 1'b0; right = 1'b0; attack = 1'b0;
        next_x = 10'd0; next_y = 10'd0; posx = 10'd0; posy = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(anim_state), 0);
        check("rst_strike", int'(strike_active), 0);
        check("rst_color", int'(color), 0);
        check("rst_hit", int'(hit), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            pix($sformatf("idle_vec%0d", i), int'(vecs[i].px), int'(vecs[i].py),
                int'(vecs[i].nx), int'(vecs[i].ny), int'(vecs[i].col), int'(vecs[i].hit));
        end

        attack = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            check($sformatf("tick%0d_state", k), int'(anim_state), exp_state(k));
            check($sformatf("tick%0d_strike", k), int'(strike_active), (exp_state(k) == 2) ? 1 : 0);
            if (k == 0) begin
                pix("windup_pal", 100, 200, 105, 200, 8'hFC, 1);
                repeat (3) @(posedge clk);
                #1;
                check("no_tick_hold", int'(anim_state), 1);
            end
            if (k == 4) begin
                pix("wpn_r_in", 100, 200, 120, 208, 8'hDB, 1);
                pix("wpn_r_end", 100, 200, 127, 208, 8'hDB, 1);
                pix("wpn_r_past", 100, 200, 128, 208, 8'h00, 0);
                pix("wpn_r_row", 100, 200, 120, 210, 8'h00, 0);
                pix("strike_pal", 100, 200, 115, 208, 8'hE0, 1);
            end
            if (k == 10) begin
                pix("recover_pal", 100, 200, 100, 200, 8'h92, 1);
            end
        end
        attack = 1'b0;

        left = 1'b1;
        tick();
        left = 1'b0;
        tick();
        tick();
        tick();
        check("left_strike_state", int'(anim_state), 2);
        pix("wpn_l_clamp", 5, 100, 3, 108, 8'hDB, 1);
        pix("wpn_l_zero", 5, 100, 0, 108, 8'hDB, 1);
        pix("mirror_u15", 5, 100, 5, 108, 8'hE0, 1);
        pix("mirror_u0", 5, 100, 20, 108, 8'h00, 0);
        pix("wpn_l_noright", 5, 100, 21, 108, 8'h00, 0);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_state", int'(anim_state), 0);
        check("midrst_strike", int'(strike_active), 0);
        check("midrst_color", int'(color), 0);
        check("midrst_hit", int'(hit), 0);
        @(negedge clk);
        rst = 1'b0;

        pix("facing_rst_right", 100, 200, 100, 214, 8'hFF, 1);
        left = 1'b1; right = 1'b1;
        tick();
        left = 1'b0; right = 1'b0;
        pix("both_hold_facing", 100, 200, 100, 214, 8'hFF, 1);
        check("both_idle", int'(anim_state), 0);
        left = 1'b1;
        tick();
        left = 1'b0;
        pix("face_left_u0", 100, 200, 100, 214, 8'h00, 0);
        pix("face_left_u15", 100, 200, 115, 214, 8'hFF, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
